spi_sclk_gen: RTL and testbench

//  Parametrised SPI serial-clock generator for the HMC7044 config path. Derives SCLK from the

---
 rtl/spi_sclk_gen.sv | 138 +++++++++++++
 tb/tb_spi_sclk_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: registered SCLK derived from clk with a runtime
// half-period divider, selectable idle polarity and burst length. Leading and
// trailing edge strobes let the shifter run entirely in the clk domain.
`timescale 1ns/1ps
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cpol,
  input  logic [DIV_W-1:0] half_div,
  input  logic [LEN_W-1:0] burst_len,
  output logic             sclk,
  output logic             lead_stb,
  output logic             trail_stb,
  output logic             done,
  output logic             busy
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   h_q, h_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   per_q, per_d;
  logic               phase_q, phase_d;
  logic               cpol_q, cpol_d;
  logic               sclk_q, sclk_d;
  logic               lead_q, lead_d;
  logic               trail_q, trail_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [DIV_W-1:0]   h_eff;
  logic [LEN_W-1:0]   per_inc;

  // A zero divider behaves as a divider of one.
  always_comb begin
    h_eff   = (half_div == '0) ? DIV_W'(1) : half_div;
    per_inc = per_q + LEN_W'(1);
  end

  // Next-state logic: idle tracking of CPOL, then half-period counting in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    len_d   = len_q;
    per_d   = per_q;
    phase_d = phase_q;
    cpol_d  = cpol_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d  = cpol;
        cnt_d   = '0;
        phase_d = 1'b0;
        busy_d  = 1'b0;
        if (en) begin
          h_d     = h_eff;
          len_d   = burst_len;
          cpol_d  = cpol;
          per_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == h_q - DIV_W'(1)) begin
          cnt_d   = '0;
          sclk_d  = ~sclk_q;
          phase_d = ~phase_q;
          if (!phase_q) begin
            lead_d = 1'b1;
          end else begin
            trail_d = 1'b1;
            per_d   = per_inc;
            h_d     = h_eff;
            // Stop only on a trailing edge so no period is ever truncated.
            if (((len_q != '0) && (per_inc == len_q)) || !en) begin
              done_d  = 1'b1;
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      len_q   <= '0;
      per_q   <= '0;
      phase_q <= 1'b0;
      cpol_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      len_q   <= len_d;
      per_q   <= per_d;
      phase_q <= phase_d;
      cpol_q  <= cpol_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign sclk      = sclk_q;
  assign lead_stb  = lead_q;
  assign trail_stb = trail_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: a schedule-based model predicts every output each
// cycle; directed bursts pin timing with hand-computed numbers.
`timescale 1ns/1ps
module tb_spi_sclk_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cpol;
  logic [7:0] half_div;
  logic [5:0] burst_len;
  logic       sclk, lead_stb, trail_stb, done, busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  spi_sclk_gen #(.DIV_W(8), .LEN_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cpol(cpol), .half_div(half_div),
    .burst_len(burst_len), .sclk(sclk), .lead_stb(lead_stb),
    .trail_stb(trail_stb), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: absolute-time schedule of the next SCLK edge.
  int unsigned cyc = 0;
  int unsigned m_h, m_next;
  logic        m_busy = 1'b0, m_hi = 1'b0, m_cpol = 1'b0;
  logic        m_sclk = 1'b0, m_lead = 1'b0, m_trail = 1'b0, m_done = 1'b0;
  logic [5:0]  m_len, m_per;

  initial begin
    logic [4:0] act_v, exp_v;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_hi = 0; m_sclk = 0; m_lead = 0; m_trail = 0; m_done = 0;
      end else begin
        m_lead = 0; m_trail = 0; m_done = 0;
        if (!m_busy) begin
          m_sclk = cpol;
          if (en) begin
            m_busy = 1; m_hi = 0;
            m_h    = (half_div == 0) ? 1 : int'(half_div);
            m_len  = burst_len; m_cpol = cpol; m_per = 0;
            m_next = cyc + m_h;
          end
        end else if (cyc == m_next) begin
          if (!m_hi) begin
            m_hi = 1; m_sclk = ~m_cpol; m_lead = 1; m_next = cyc + m_h;
          end else begin
            m_hi = 0; m_sclk = m_cpol; m_trail = 1; m_per = m_per + 6'd1;
            m_h    = (half_div == 0) ? 1 : int'(half_div);
            m_next = cyc + m_h;
            if ((m_len != 0 && m_per == m_len) || !en) begin
              m_done = 1; m_busy = 0;
            end
          end
        end
      end
      #1;
      act_v = {sclk, lead_stb, trail_stb, done, busy};
      exp_v = {m_sclk, m_lead, m_trail, m_done, m_busy};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle %0d {sclk,lead,trail,done,busy}: got %b expected %b", cyc, act_v, exp_v);
      end
    end
  end

  task automatic wait_idle();
    int unsigned k = 0;
    @(negedge clk); en = 0;
    while (busy && k < 500) begin @(negedge clk); k++; end
    check("idle_before_burst", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  // mode 0: plain burst; 1: half_div -> 2 during period 3; 2: drop en after 2nd lead
  task automatic run_burst(input string nm, input logic c, input logic [7:0] hd,
                           input logic [5:0] bl, input int unsigned mode,
                           input int unsigned exp_t, input int unsigned exp_first,
                           input int unsigned exp_leads, input logic exp_sclk);
    int unsigned t = 0, leads = 0, trails = 0, mleads = 0, first = 0, lt = 0, extra = 0;
    logic got = 0;
    wait_idle();
    cpol = c; half_div = hd; burst_len = bl; en = 1;
    @(posedge clk);
    while (!got && t < 400) begin
      @(posedge clk); #1; t++;
      if (m_lead) mleads++;
      if (trail_stb) trails++;
      if (lead_stb) begin
        leads++;
        if (leads == 1) first = t;
        if (leads == 2) lt = t;
      end
      if (done) got = 1;
      else if (mode == 1 && t == 18) begin @(negedge clk); half_div = 8'd2; end
      else if (mode == 2 && leads == 2 && t == lt + 1) begin @(negedge clk); en = 0; end
    end
    @(negedge clk); en = 0;
    check({nm, "_done_seen"}, got, 1);
    check({nm, "_done_time"}, t, exp_t);
    check({nm, "_first_lead"}, first, exp_first);
    check({nm, "_leads"}, leads, exp_leads);
    check({nm, "_trails"}, trails, exp_leads);
    check({nm, "_model_leads"}, mleads, exp_leads);
    check({nm, "_end_sclk"}, sclk, exp_sclk);
    repeat (12) begin @(posedge clk); #1; if (lead_stb || trail_stb) extra++; end
    check({nm, "_no_extra_edges"}, extra, 0);
    check({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int unsigned k;
    rst_n = 0; en = 0; cpol = 0; half_div = 8'd4; burst_len = 6'd0;
    @(posedge clk); #1;
    check("reset_outputs", {sclk, lead_stb, trail_stb, done, busy}, 0);
    @(negedge clk); rst_n = 1;

    run_burst("h4_len24",   1'b0, 8'd4, 6'd24, 0, 192, 4, 24, 1'b0);
    run_burst("cpol1_h2",   1'b1, 8'd2, 6'd3,  0, 12,  2, 3,  1'b1);
    run_burst("h0_len2",    1'b0, 8'd0, 6'd2,  0, 4,   1, 2,  1'b0);
    run_burst("hdchange",   1'b0, 8'd4, 6'd8,  1, 44,  4, 8,  1'b0);
    run_burst("freerun_en", 1'b0, 8'd3, 6'd0,  2, 12,  3, 2,  1'b0);

    // Asynchronous reset in the middle of a high phase.
    wait_idle();
    cpol = 0; half_div = 8'd4; burst_len = 6'd5; en = 1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!lead_stb && k < 100);
    check("rst_lead_seen", lead_stb, 1);
    @(posedge clk); @(posedge clk); #1;
    check("rst_sclk_high_before", sclk, 1);
    #3 rst_n = 0;
    #1 check("rst_async_outputs", {sclk, lead_stb, trail_stb, done, busy}, 0);
    en = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    run_burst("post_reset", 1'b0, 8'd0, 6'd2, 0, 4, 1, 2, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) half_div = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) burst_len = 6'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) cpol = ~cpol;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 0; @(negedge clk); rst_n = 1;
      end
    end
    en = 0;
    repeat (100) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
